sound_source_sched: RTL
=======================

// Module: sound_source_sched
// PURPOSE
//   Paces stereo audio into the APF I2S generator at exactly 48 kHz from clk_74a.
//   Arbitrates or mixes two requesters (A: core audio, B: system/UI audio) via valid/ready.
//   Presents held signed samples on audio_l/audio_r for the I2S bridge (SIGNED_INPUT=1).
// PARAMETERS
//   WIDTH          16  signed sample width per channel (<=16)
//   UNDERRUN_HOLD  1   1: repeat last output on underrun; 0: output zero
// PORTS
//   clk_74a        in   1      74.25 MHz clock; sole clock domain
//   reset          in   1      synchronous, active-high reset
//   mode           in   2      0 A_ONLY, 1 A_PRIO, 2 MIX, 3 MUTE; sampled on tick
//   a_valid        in   1      source A sample valid
//   a_ready        out  1      source A holding register empty
//   a_l, a_r       in   WIDTH  source A left/right, signed
//   b_valid        in   1      source B sample valid
//   b_ready        out  1      source B holding register empty
//   b_l, b_r       in   WIDTH  source B left/right, signed
//   audio_l        out  WIDTH  to I2S left
//   audio_r        out  WIDTH  to I2S right
//   sample_strobe  out  1      1-cycle pulse when audio_l/r update
//   underrun       out  1      1-cycle pulse: tick with no selected sample
//   underrun_count out  16     (SOUND_SCHED_STATS_EN only)
// BEHAVIOUR
//   Reset: audio_l/r=0, sample_strobe=0, underrun=0, a_ready=b_ready=1, accum=0, state IDLE.
//   Tick: 14-bit accum += 8 each cycle; if accum+8 >= 12375 then accum <= accum+8-12375 and tick=1.
//     Period 1546/1547 cycles; exactly 8 ticks per 12375 cycles; first tick at cycle 1547.
//   Holding regs: one entry per source; x_ready = ~full (registered); accept on x_valid&x_ready.
//     Consume on tick clears full; ready rises next cycle; accept and consume never share a cycle.
//   States: IDLE (outputs 0, no underrun pulses) -> RUN on first tick that selects a sample.
//     RUN stays until reset.
//   On tick, next cycle: audio_l/r update and sample_strobe=1, per mode:
//     A_ONLY: A if full (consume A); B untouched (fills, then stalls).
//     A_PRIO: A if full (consume A, B stays full); else B if full (consume B).
//     MIX: sum of full registers (empty counts 0); WIDTH+1-bit add; saturate to
//       [-2^(WIDTH-1), 2^(WIDTH-1)-1] per channel; consume every full register.
//     MUTE: output 0; consume both (drain); never underrun.
//   Underrun (RUN, mode!=MUTE, no selected register full): underrun=1 with sample_strobe;
//     output = last value if UNDERRUN_HOLD else 0.
//   Latency: sample accepted before tick cycle T appears on audio_l/r at T+1.
//   Mode changes between ticks take effect only at the next tick.
//   Reset mid-operation discards held samples; tick phase restarts from 0.
// CONFIGURATION
//   SOUND_SCHED_STATS_EN defined: underrun_count increments on each underrun pulse.
//     Saturates at 16'hFFFF; reset to 0.
//   Undefined: port absent, no counter logic.
// STRUCTURE
//   Package sound_pkg: mode_e enum (A_ONLY/A_PRIO/MIX/MUTE), TICK_INC=8, TICK_MOD=12375,
//     sat_add function.
//   Sub-module sound_rate_tick: fractional accumulator producing the 48 kHz tick.
// TESTING
//   Reset, mode 0, no input: outputs 0, a/b_ready=1, first tick at 1547, 8 ticks in 12375 cycles,
//     no underrun in IDLE.
//   A_PRIO, A=(0x1234,0x5678), B=(0x0ABC,0x0DEF) before tick: out A; B full, b_ready=0;
//     next tick out B.
//   MIX: A=0x7000, B=0x2000 -> 0x7FFF; A=0x9000(-0x7000), B=0xE000 -> 0x8000;
//     A=0x0100 alone -> 0x0100.
//   UNDERRUN_HOLD=1: one A sample 0x0100 then none -> output stays 0x0100, underrun each tick;
//     UNDERRUN_HOLD=0 -> output 0.
//   MUTE with both full: output 0, both ready high after tick, underrun=0.
//     Reset mid-run clears outputs next cycle.
//   STATS_EN: 3 underruns -> count 3; preload/force 0xFFFF + underrun -> stays 0xFFFF.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types, tick constants and saturating adder for the 48 kHz audio scheduler.
package sound_pkg;

    localparam int unsigned TICK_W   = 14;
    localparam int unsigned TICK_INC = 8;
    localparam int unsigned TICK_MOD = 12375;
    localparam int unsigned SAMP_MAX_W = 16;

    typedef enum logic [1:0] {
        A_ONLY = 2'd0,
        A_PRIO = 2'd1,
        MIX    = 2'd2,
        MUTE   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // Adds two sign-extended samples and clamps to the signed range of a w-bit sample.
    function automatic logic signed [15:0] sat_add(input logic signed [15:0] a,
                                                   input logic signed [15:0] b,
                                                   input int unsigned        w);
        logic signed [16:0] sum;
        logic signed [16:0] hi;
        logic signed [16:0] lo;
        sum = $signed({a[15], a}) + $signed({b[15], b});
        hi  = (17'sd1 <<< (w - 1)) - 17'sd1;
        lo  = -(17'sd1 <<< (w - 1));
        if (sum > hi) begin
            sat_add = hi[15:0];
        end else if (sum < lo) begin
            sat_add = lo[15:0];
        end else begin
            sat_add = sum[15:0];
        end
    endfunction

endpackage

// File: rtl/sound_rate_tick.sv
// Fractional accumulator: 8/12375 of clk_74a (74.25 MHz) gives an exact 48 kHz tick.
module sound_rate_tick
    import sound_pkg::*;
(
    input  logic i_clk,
    input  logic i_reset,
    output logic o_tick_c
);

    localparam int unsigned SUM_W = TICK_W + 1;

    logic [TICK_W-1:0] r_accum;
    logic [SUM_W-1:0]  w_sum;

    assign w_sum    = {1'b0, r_accum} + SUM_W'(TICK_INC);
    assign o_tick_c = (w_sum >= SUM_W'(TICK_MOD));

    // Phase accumulator; wraps modulo TICK_MOD on each tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_accum <= '0;
        end else if (o_tick_c) begin
            r_accum <= TICK_W'(w_sum - SUM_W'(TICK_MOD));
        end else begin
            r_accum <= TICK_W'(w_sum);
        end
    end

endmodule

// File: rtl/sound_source_sched.sv
// 48 kHz stereo sample scheduler: arbitrates/mixes sources A and B into held I2S samples.
// Optional build macro SOUND_SCHED_STATS_EN adds a saturating underrun_count output.
module sound_source_sched
    import sound_pkg::*;
#(
    parameter int unsigned WIDTH         = 16,
    parameter bit          UNDERRUN_HOLD = 1'b1
)
(
    input  logic             clk_74a,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_l,
    input  logic [WIDTH-1:0] a_r,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_l,
    input  logic [WIDTH-1:0] b_r,
    output logic [WIDTH-1:0] audio_l,
    output logic [WIDTH-1:0] audio_r,
    output logic             sample_strobe,
    output logic             underrun
`ifdef SOUND_SCHED_STATS_EN
    ,
    output logic [15:0]      underrun_count
`endif
);

    logic             w_tick;
    mode_e            w_mode;
    sched_state_e     r_state;
    sched_state_e     w_state_next;

    logic             r_a_ready;
    logic             r_b_ready;
    logic [WIDTH-1:0] r_a_l;
    logic [WIDTH-1:0] r_a_r;
    logic [WIDTH-1:0] r_b_l;
    logic [WIDTH-1:0] r_b_r;
    logic             w_a_full;
    logic             w_b_full;
    logic             w_accept_a;
    logic             w_accept_b;

    logic             w_sel;
    logic             w_consume_a;
    logic             w_consume_b;
    logic             w_under;
    logic [WIDTH-1:0] w_out_l;
    logic [WIDTH-1:0] w_out_r;

    logic signed [15:0] w_a_l16;
    logic signed [15:0] w_a_r16;
    logic signed [15:0] w_b_l16;
    logic signed [15:0] w_b_r16;
    logic [WIDTH-1:0]   w_mix_l;
    logic [WIDTH-1:0]   w_mix_r;

    logic [WIDTH-1:0] r_audio_l;
    logic [WIDTH-1:0] r_audio_r;
    logic             r_strobe;
    logic             r_underrun;

    sound_rate_tick u_tick (
        .i_clk    (clk_74a),
        .i_reset  (reset),
        .o_tick_c (w_tick)
    );

    assign w_mode     = mode_e'(mode);
    assign w_a_full   = ~r_a_ready;
    assign w_b_full   = ~r_b_ready;
    assign w_accept_a = a_valid & r_a_ready;
    assign w_accept_b = b_valid & r_b_ready;

    // Empty holding registers contribute zero to the mix.
    assign w_a_l16 = w_a_full ? 16'($signed(r_a_l)) : 16'sd0;
    assign w_a_r16 = w_a_full ? 16'($signed(r_a_r)) : 16'sd0;
    assign w_b_l16 = w_b_full ? 16'($signed(r_b_l)) : 16'sd0;
    assign w_b_r16 = w_b_full ? 16'($signed(r_b_r)) : 16'sd0;
    assign w_mix_l = WIDTH'(sat_add(w_a_l16, w_b_l16, WIDTH));
    assign w_mix_r = WIDTH'(sat_add(w_a_r16, w_b_r16, WIDTH));

    // Source A holding register; ready is the registered empty flag.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_a_ready <= 1'b1;
            r_a_l     <= '0;
            r_a_r     <= '0;
        end else if (w_accept_a) begin
            r_a_ready <= 1'b0;
            r_a_l     <= a_l;
            r_a_r     <= a_r;
        end else if (w_consume_a) begin
            r_a_ready <= 1'b1;
        end
    end

    // Source B holding register; ready is the registered empty flag.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_b_ready <= 1'b1;
            r_b_l     <= '0;
            r_b_r     <= '0;
        end else if (w_accept_b) begin
            r_b_ready <= 1'b0;
            r_b_l     <= b_l;
            r_b_r     <= b_r;
        end else if (w_consume_b) begin
            r_b_ready <= 1'b1;
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Per-tick selection, consumption, underrun detection and next state.
    always_comb begin
        w_state_next = r_state;
        w_sel        = 1'b0;
        w_consume_a  = 1'b0;
        w_consume_b  = 1'b0;
        w_under      = 1'b0;
        w_out_l      = r_audio_l;
        w_out_r      = r_audio_r;
        if (w_tick) begin
            case (w_mode)
                A_ONLY: begin
                    if (w_a_full) begin
                        w_sel       = 1'b1;
                        w_consume_a = 1'b1;
                        w_out_l     = r_a_l;
                        w_out_r     = r_a_r;
                    end
                end
                A_PRIO: begin
                    if (w_a_full) begin
                        w_sel       = 1'b1;
                        w_consume_a = 1'b1;
                        w_out_l     = r_a_l;
                        w_out_r     = r_a_r;
                    end else if (w_b_full) begin
                        w_sel       = 1'b1;
                        w_consume_b = 1'b1;
                        w_out_l     = r_b_l;
                        w_out_r     = r_b_r;
                    end
                end
                MIX: begin
                    w_consume_a = w_a_full;
                    w_consume_b = w_b_full;
                    if (w_a_full || w_b_full) begin
                        w_sel   = 1'b1;
                        w_out_l = w_mix_l;
                        w_out_r = w_mix_r;
                    end
                end
                MUTE: begin
                    w_consume_a = w_a_full;
                    w_consume_b = w_b_full;
                    w_out_l     = '0;
                    w_out_r     = '0;
                end
                default: begin
                end
            endcase
            if (w_sel) begin
                w_state_next = ST_RUN;
            end else if ((w_mode != MUTE) && (r_state == ST_RUN)) begin
                w_under = 1'b1;
                if (!UNDERRUN_HOLD) begin
                    w_out_l = '0;
                    w_out_r = '0;
                end
            end
        end
    end

    // Output sample registers and per-tick pulses.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_audio_l  <= '0;
            r_audio_r  <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_strobe   <= w_tick;
            r_underrun <= w_under;
            if (w_tick) begin
                r_audio_l <= w_out_l;
                r_audio_r <= w_out_r;
            end
        end
    end

    assign a_ready       = r_a_ready;
    assign b_ready       = r_b_ready;
    assign audio_l       = r_audio_l;
    assign audio_r       = r_audio_r;
    assign sample_strobe = r_strobe;
    assign underrun      = r_underrun;

`ifdef SOUND_SCHED_STATS_EN
    logic [15:0] r_underrun_count;

    // Saturating count of underrun pulses.
    always_ff @(posedge clk_74a) begin
        if (reset) begin
            r_underrun_count <= '0;
        end else if (w_under && (r_underrun_count != 16'hFFFF)) begin
            r_underrun_count <= r_underrun_count + 16'd1;
        end
    end

    assign underrun_count = r_underrun_count;
`endif

endmodule
